// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch (F0-F3), up to five execute steps (E0-E4),
// HALT. Outputs depend only on the current state, the opcode in IR and one latched branch flag.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);

    localparam logic [3:0] StRst  = 4'd0;
    localparam logic [3:0] StF0   = 4'd1;
    localparam logic [3:0] StF1   = 4'd2;
    localparam logic [3:0] StF2   = 4'd3;
    localparam logic [3:0] StF3   = 4'd4;
    localparam logic [3:0] StE0   = 4'd5;
    localparam logic [3:0] StE1   = 4'd6;
    localparam logic [3:0] StE2   = 4'd7;
    localparam logic [3:0] StE3   = 4'd8;
    localparam logic [3:0] StE4   = 4'd9;
    localparam logic [3:0] StHalt = 4'd10;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpDiv  = 5'b01111;
    localparam logic [4:0] OpMul  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam logic [4:0] AluAdd = 5'b00011;
    localparam logic [4:0] AluAnd = 5'b00101;
    localparam logic [4:0] AluOr  = 5'b00110;
    localparam logic [4:0] AluNop = 5'b11010;

    // Instruction classes: opcodes sharing one execute sequence.
    localparam logic [3:0] ClsNop  = 4'd0;
    localparam logic [3:0] ClsLd   = 4'd1;
    localparam logic [3:0] ClsLdi  = 4'd2;
    localparam logic [3:0] ClsSt   = 4'd3;
    localparam logic [3:0] ClsAlu  = 4'd4;
    localparam logic [3:0] ClsImm  = 4'd5;
    localparam logic [3:0] ClsMd   = 4'd6;
    localparam logic [3:0] ClsUn   = 4'd7;
    localparam logic [3:0] ClsBr   = 4'd8;
    localparam logic [3:0] ClsJr   = 4'd9;
    localparam logic [3:0] ClsIn   = 4'd10;
    localparam logic [3:0] ClsOut  = 4'd11;
    localparam logic [3:0] ClsMfhi = 4'd12;
    localparam logic [3:0] ClsMflo = 4'd13;
    localparam logic [3:0] ClsHalt = 4'd14;

    logic [3:0] state_q, state_d;
    logic       con_q, con_d;
    logic [4:0] opcode;
    logic [3:0] cls;
    logic [4:0] imm_alu;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_comb begin
        cls = ClsNop;
        case (opcode) inside
            OpLd:                  cls = ClsLd;
            OpLdi:                 cls = ClsLdi;
            OpSt:                  cls = ClsSt;
            [5'b00011:5'b01011]:   cls = ClsAlu;
            OpAddi, OpAndi, OpOri: cls = ClsImm;
            OpDiv, OpMul:          cls = ClsMd;
            OpNeg, OpNot:          cls = ClsUn;
            OpBr:                  cls = ClsBr;
            OpJr:                  cls = ClsJr;
            OpIn:                  cls = ClsIn;
            OpOut:                 cls = ClsOut;
            OpMfhi:                cls = ClsMfhi;
            OpMflo:                cls = ClsMflo;
            OpHalt:                cls = ClsHalt;
            default:               cls = ClsNop;
        endcase
    end

    always_comb begin
        imm_alu = AluOr;
        if (opcode == OpAddi) begin
            imm_alu = AluAdd;
        end else if (opcode == OpAndi) begin
            imm_alu = AluAnd;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StRst;
            con_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            con_q   <= con_d;
        end
    end

    // CON_FF was loaded in E0, so it is stable by the E2->E3 edge; latching it there
    // keeps the E3 strobes a pure function of state.
    always_comb begin
        con_d = con_q;
        if (state_q == StE2 && cls == ClsBr) begin
            con_d = CON;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRst: state_d = StF0;
            StF0:  state_d = StF1;
            StF1:  state_d = StF2;
            StF2: begin
                if (mem_ready) begin
                    state_d = StF3;
                end
            end
            StF3:  state_d = StE0;
            StE0: begin
                case (cls)
                    ClsHalt:                                      state_d = StHalt;
                    ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop: state_d = StF0;
                    default:                                      state_d = StE1;
                endcase
            end
            StE1: begin
                state_d = (cls == ClsUn) ? StF0 : StE2;
            end
            StE2: begin
                case (cls)
                    ClsLd, ClsSt, ClsMd, ClsBr: state_d = StE3;
                    default:                    state_d = StF0;
                endcase
            end
            StE3: begin
                case (cls)
                    ClsLd: begin
                        if (mem_ready) begin
                            state_d = StE4;
                        end
                    end
                    ClsSt:   state_d = StE4;
                    default: state_d = StF0;
                endcase
            end
            StE4: begin
                if (cls != ClsSt || mem_ready) begin
                    state_d = StF0;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        Zhighout  = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        InPortout = 1'b0;
        Cout      = 1'b0;
        PCin      = 1'b0;
        IRin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        OutPortin = 1'b0;
        CONin     = 1'b0;
        IncPC     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        BAout     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        alu_op    = AluNop;
        Run       = 1'b1;
        case (state_q)
            StF0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StF1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
            end
            StF2: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            StF3: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StE0: begin
                case (cls)
                    ClsLd, ClsLdi, ClsSt: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    ClsAlu, ClsImm: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    ClsMd: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    ClsUn: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                    end
                    ClsBr: begin
                        Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                    end
                    ClsJr: begin
                        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    end
                    ClsIn: begin
                        InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    ClsOut: begin
                        Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
                    end
                    ClsMfhi: begin
                        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    ClsMflo: begin
                        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            StE1: begin
                case (cls)
                    ClsLd, ClsLdi, ClsSt: begin
                        Cout = 1'b1; Zin = 1'b1; alu_op = AluAdd;
                    end
                    ClsAlu: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                    end
                    ClsImm: begin
                        Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu;
                    end
                    ClsMd: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                    end
                    ClsUn: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    ClsBr: begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            StE2: begin
                case (cls)
                    ClsLd, ClsSt: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    ClsLdi, ClsAlu, ClsImm: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    ClsMd: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    ClsBr: begin
                        Cout = 1'b1; Zin = 1'b1; alu_op = AluAdd;
                    end
                    default: ;
                endcase
            end
            StE3: begin
                case (cls)
                    ClsLd: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    ClsSt: begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end
                    ClsMd: begin
                        Zhighout = 1'b1; HIin = 1'b1;
                    end
                    ClsBr: begin
                        Zlowout = con_q;
                        PCin    = con_q;
                    end
                    default: ;
                endcase
            end
            StE4: begin
                case (cls)
                    ClsLd: begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    ClsSt:   Write = 1'b1;
                    default: ;
                endcase
            end
            StHalt: Run = 1'b0;
            default: ;
        endcase
    end

endmodule
